// File: rtl/popcount11_combgen.sv
// Enumerates every N-bit vector of popcount k in ascending order.
// One vector per cycle via a single-cycle next-same-popcount step.
module popcount11_combgen #(
    parameter int N  = 11,
    parameter int KW = 4,
    parameter int IW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec,
    output logic [IW-1:0] vec_idx,
    output logic          vec_last,
    output logic          done,
    output logic          err
);

    localparam int TZW = $clog2(N);
    localparam logic [KW-1:0] KMAX = KW'(N);
    localparam logic [N-1:0]  ALL  = '1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   vec_q, vec_n;
    logic [N-1:0]   lastv_q, lastv_n;
    logic [IW-1:0]  idx_q, idx_n;
    logic           done_q, done_n;
    logic           err_q, err_n;
    logic           is_last;

    logic [N-1:0]   low_bit;
    logic [N-1:0]   ripple;
    logic [N-1:0]   ones;
    logic [N-1:0]   succ;
    logic [TZW-1:0] tz;

    assign is_last   = (state == EMIT) && (vec_q == lastv_q);
    assign busy      = (state == EMIT);
    assign vec_valid = (state == EMIT);
    assign vec       = vec_q;
    assign vec_idx   = idx_q;
    assign vec_last  = is_last;
    assign done      = done_q;
    assign err       = err_q;

    // Successor: add lowest set bit, then refill the dropped ones at the bottom.
    always_comb begin
        low_bit = vec_q & (~vec_q + N'(1));
        ripple  = vec_q + low_bit;
        tz      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_q[i]) tz = TZW'(i);
        end
        ones = ((ripple ^ vec_q) >> 2) >> tz;
        succ = ripple | ones;
    end

    // Next-state and datapath updates; vector regs are zero outside EMIT.
    always_comb begin
        state_n = state;
        vec_n   = vec_q;
        lastv_n = lastv_q;
        idx_n   = idx_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (k > KMAX) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = EMIT;
                        vec_n   = ~(ALL << k);
                        lastv_n = ~(ALL >> k);
                        idx_n   = '0;
                    end
                end
            end
            EMIT: begin
                if (vec_ready) begin
                    if (is_last) begin
                        state_n = IDLE;
                        vec_n   = '0;
                        lastv_n = '0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        vec_n = succ;
                        idx_n = idx_q + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_q   <= '0;
            lastv_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            vec_q   <= vec_n;
            lastv_q <= lastv_n;
            idx_q   <= idx_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_popcount11_combgen.sv
// Directed bench for popcount11_combgen.
// Table of full enumerations plus hand sequences for corner cases.
module tb_popcount11_combgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  k;
    logic        busy;
    logic        vec_valid;
    logic        vec_ready;
    logic [10:0] vec;
    logic [8:0]  vec_idx;
    logic        vec_last;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount11_combgen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec       (vec),
        .vec_idx   (vec_idx),
        .vec_last  (vec_last),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [3:0]  kv;
        bit          rnd;
        int          n;
        logic [10:0] first;
        logic [10:0] last;
    } enum_t;

    enum_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Outputs bundled as {busy,valid,last,done,err,idx,vec}
    function automatic int pack_out();
        return int'({busy, vec_valid, vec_last, done, err, vec_idx, vec});
    endfunction

    function automatic logic [10:0] nxt(input logic [10:0] v, input logic [3:0] kk);
        logic [10:0] xv;
        for (int x = int'(v) + 1; x < 2048; x++) begin
            xv = 11'(x);
            if ($countones(xv) == int'(kk)) return xv;
        end
        return '0;
    endfunction

    task automatic run_enum(input enum_t t, input string nm);
        logic [10:0] ev;
        logic [8:0]  ei;
        int          cnt;
        int          guard;
        bit          fin;
        bit          r;
        bit          ok;
        ev    = t.first;
        ei    = '0;
        cnt   = 0;
        guard = 0;
        fin   = 1'b0;
        start = 1'b1;
        k     = t.kv;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && guard < 3000) begin
            guard++;
            ok = vec_valid && busy && !done && !err && vec == ev &&
                 vec_idx == ei && vec_last == (ev == t.last) &&
                 $countones(vec) == int'(t.kv);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s_emit: got vec=%h idx=%0d last=%b valid=%b expected vec=%h idx=%0d last=%b",
                         nm, vec, vec_idx, vec_last, vec_valid, ev, ei, ev == t.last);
            end
            r = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vec_ready = r;
            @(posedge clk); #1;
            if (r) begin
                cnt++;
                if (ev == t.last) fin = 1'b1;
                else begin
                    ev = nxt(ev, t.kv);
                    ei = ei + 9'd1;
                end
            end
        end
        vec_ready = 1'b0;
        check({nm, "_finished"}, int'(fin), 1);
        check({nm, "_count"}, cnt, t.n);
        check({nm, "_done_pulse"}, pack_out(), int'({5'b00010, 20'h0}));
        @(posedge clk); #1;
        check({nm, "_done_clear"}, pack_out(), 0);
    endtask

    initial begin
        tbl[0] = '{4'd0,  1'b0, 1,   11'h000, 11'h000};
        tbl[1] = '{4'd1,  1'b0, 11,  11'h001, 11'h400};
        tbl[2] = '{4'd11, 1'b0, 1,   11'h7FF, 11'h7FF};
        tbl[3] = '{4'd5,  1'b1, 462, 11'h01F, 11'h7C0};
        tbl[4] = '{4'd2,  1'b0, 55,  11'h003, 11'h600};
        tbl[5] = '{4'd10, 1'b1, 11,  11'h3FF, 11'h7FE};
        tbl[6] = '{4'd3,  1'b0, 165, 11'h007, 11'h700};
        tbl[7] = '{4'd6,  1'b1, 462, 11'h03F, 11'h7E0};

        rst_n     = 1'b0;
        start     = 1'b0;
        k         = '0;
        vec_ready = 1'b0;
        #1;
        check("reset_state", pack_out(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_reset_idle", pack_out(), 0);
        end

        for (int i = 0; i < 8; i++) begin
            run_enum(tbl[i], $sformatf("tbl%0d_k%0d", i, tbl[i].kv));
        end

        // k beyond N: error pulse, no enumeration
        for (int kk = 12; kk <= 15; kk += 3) begin
            start = 1'b1;
            k     = 4'(kk);
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("err_pulse_k%0d", kk), pack_out(), int'({5'b00001, 20'h0}));
            @(posedge clk); #1;
            check($sformatf("err_clear_k%0d", kk), pack_out(), 0);
        end

        // Reset in the middle of k=3 enumeration
        begin
            int g;
            g = 0;
            start = 1'b1;
            k     = 4'd3;
            @(posedge clk); #1;
            start     = 1'b0;
            vec_ready = 1'b1;
            while (vec_idx != 9'd40 && g < 300) begin
                @(posedge clk); #1;
                g++;
            end
            check("midreset_reach40", int'(vec_idx), 40);
            rst_n = 1'b0;
            #1;
            check("midreset_async_clear", pack_out(), 0);
            vec_ready = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                check("midreset_no_done", pack_out(), 0);
            end
            run_enum(tbl[4], "after_reset_k2");
        end

        // start while busy ignored; start on the done cycle accepted
        begin
            int g;
            int cnt;
            start = 1'b1;
            k     = 4'd11;
            @(posedge clk); #1;
            k = 4'd1;
            repeat (3) begin
                @(posedge clk); #1;
                check("busy_start_ignored", pack_out(), int'({5'b11100, 9'd0, 11'h7FF}));
            end
            start     = 1'b0;
            vec_ready = 1'b1;
            @(posedge clk); #1;
            vec_ready = 1'b0;
            check("done_cycle", pack_out(), int'({5'b00010, 20'h0}));
            start = 1'b1;
            k     = 4'd1;
            @(posedge clk); #1;
            start = 1'b0;
            check("restart_on_done", pack_out(), int'({5'b11000, 9'd0, 11'h001}));
            vec_ready = 1'b1;
            g   = 0;
            cnt = 0;
            while (!done && g < 50) begin
                if (vec_valid) cnt++;
                @(posedge clk); #1;
                g++;
            end
            vec_ready = 1'b0;
            check("restart_done_seen", int'(done), 1);
            check("restart_count", cnt, 11);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount11_combgen.md
POPCOUNT11_COMBGEN -- requirements
Module: popcount11_combgen

Interface
REQ-001 Parameter N, default 11, vector width; matches the 11-input popcount blocks under characterization.
REQ-002 Parameter KW, default 4, width of the target-count input.
REQ-003 Parameter IW, default 9, width of the emitted-vector index (C(11,5)=462 < 512).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a new enumeration; sampled only in IDLE.
REQ-007 k  input  KW  target popcount; sampled with start.
REQ-008 busy  output  1  high while not in IDLE.
REQ-009 vec_valid  output  1  vec/vec_idx/vec_last are valid.
REQ-010 vec_ready  input  1  consumer accepts the current vector.
REQ-011 vec  output  N  current vector with popcount exactly k.
REQ-012 vec_idx  output  IW  zero-based position of vec within the enumeration.
REQ-013 vec_last  output  1  vec is the final vector of the enumeration.
REQ-014 done  output  1  one-cycle pulse after the last vector is accepted.
REQ-015 err  output  1  one-cycle pulse when start arrives with k > N.

Function
REQ-016 The block SHALL be the inverse of a popcount: for target k it emits every N-bit vector whose popcount equals k, each exactly once, C(N,k) vectors total.
REQ-017 Order SHALL be strictly ascending unsigned value: first vector (2^k)-1, last vector ((2^k)-1) << (N-k).
REQ-018 The next vector SHALL be the smallest N-bit value greater than the current one with equal popcount, computed in one cycle (lowest-set-bit / ripple / shift method).
REQ-019 States SHALL be IDLE and EMIT only.
REQ-020 IDLE, start=1, k<=N: load vec=(2^k)-1, vec_idx=0, enter EMIT next cycle; vec_valid high from that cycle.
REQ-021 IDLE, start=1, k>N: stay IDLE, err=1 for one cycle, no vector emitted.
REQ-022 EMIT: vec_valid=1 continuously; vec, vec_idx, vec_last SHALL hold stable while vec_ready=0.
REQ-023 EMIT, vec_valid&vec_ready, vec_last=0: advance vec to successor, vec_idx+1, next cycle; one vector per cycle at full throughput.
REQ-024 EMIT, vec_valid&vec_ready, vec_last=1: return to IDLE, done=1 the following cycle, vec_valid=0.
REQ-025 vec_last SHALL be 1 exactly when vec equals ((2^k)-1) << (N-k); k=0 and k=N yield a single vector with vec_last=1.
REQ-026 start while busy SHALL be ignored (no restart, no err).
REQ-027 start coincident with the done cycle SHALL be accepted (IDLE already entered).
REQ-028 Outside EMIT, vec, vec_idx, vec_last SHALL read 0.
REQ-029 vec_idx SHALL never exceed C(N,k)-1; no wrap-around occurs.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, vec_valid=0, vec=0, vec_idx=0, vec_last=0, done=0, err=0.
REQ-031 Reset during EMIT SHALL abandon the enumeration with no done pulse; first start after release begins a fresh enumeration.
REQ-032 Outputs SHALL remain at reset values until the first accepted start after rst_n rises.

Verification
REQ-033 k=0, ready=1 -> one vector 0x000, idx 0, vec_last=1, done pulse next cycle.
REQ-034 k=1, ready=1 -> 11 vectors 0x001,0x002,...,0x400 on consecutive cycles, last at idx 10.
REQ-035 k=11 -> single vector 0x7FF, vec_last=1; k=12 -> err pulse, busy stays 0.
REQ-036 k=5, random vec_ready -> 462 distinct vectors, each popcount 5, ascending, first 0x01F, last 0x7C0, stable under stall.
REQ-037 k=3, rst_n pulsed low at idx 40 -> all outputs 0 at once, no done; new start k=2 yields 55 vectors from 0x003.
REQ-038 start during EMIT and start on done cycle -> first ignored, second begins new enumeration next cycle.
